// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: request held until ready, read data
// returned later with an rvalid strobe. One transaction outstanding at a time.
interface mem_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        wen;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, wen, mask, wdata, input ready, rvalid, rdata);
  modport slave  (input req, addr, wen, mask, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores on the data-memory port,
// aligns/extends load data, and registers the MEM/WB entry.
module mem_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vld,
  input  logic [31:0] i_res,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_opsel,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_reg,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic [31:0] i_pc,
  mem_stage_if.master dmem,
  output logic        o_stall,
  output logic        o_vld,
  output logic [4:0]  o_rd_waddr,
  output logic        o_rd_wen,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_pc,
  output logic        o_trap_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lane;
  logic        size_b, size_h, size_w;
  logic        is_mem, misaligned, mem_go, wb_load;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign lane       = i_res[1:0];
  assign size_b     = (i_opsel[1:0] == 2'b00);
  assign size_h     = (i_opsel[1:0] == 2'b01);
  // funct3[1] set covers W and the reserved encodings 011/110/111, all word-sized.
  assign size_w     = i_opsel[1];
  assign is_mem     = i_mem_read | i_mem_write;
  assign misaligned = is_mem & ((size_h & lane[0]) | (size_w & (lane != 2'b00)));
  assign mem_go     = i_vld & is_mem & ~misaligned;

  always_comb begin
    // NOTE: every signal gets a default first so no latch can be inferred.
    st_mask  = 4'b0000;
    st_wdata = i_wdata;
    if (i_mem_write) begin
      if (size_b) begin
        st_mask  = 4'b0001 << lane;
        st_wdata = {4{i_wdata[7:0]}};
      end else if (size_h) begin
        st_mask  = lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_wdata[15:0]}};
      end else begin
        st_mask  = 4'b1111;
      end
    end
  end

  // Upstream holds EX/MEM while stalled, so these stay stable until ready.
  assign dmem.addr  = {i_res[31:2], 2'b00};
  assign dmem.wen   = i_mem_write;
  assign dmem.mask  = st_mask;
  assign dmem.wdata = st_wdata;

  always_comb begin
    case (lane)
      2'b00:   ld_byte = dmem.rdata[7:0];
      2'b01:   ld_byte = dmem.rdata[15:8];
      2'b10:   ld_byte = dmem.rdata[23:16];
      default: ld_byte = dmem.rdata[31:24];
    endcase
    ld_half = lane[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    ld_data = dmem.rdata;
    if (size_b)
      ld_data = {{24{~i_opsel[2] & ld_byte[7]}}, ld_byte};
    else if (size_h)
      ld_data = {{16{~i_opsel[2] & ld_half[15]}}, ld_half};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: clocked state uses non-blocking assignment so every flop sees pre-edge values.
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_go) state_nxt = REQ;
      REQ:     if (dmem.ready) state_nxt = i_mem_write ? IDLE : WAIT;
      WAIT:    if (dmem.rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem.req = 1'b0;
    o_stall  = 1'b0;
    case (state)
      IDLE:    o_stall = mem_go;
      REQ: begin
        dmem.req = 1'b1;
        o_stall  = ~(dmem.ready & i_mem_write);
      end
      WAIT:    o_stall = ~dmem.rvalid;
      default: o_stall = 1'b0;
    endcase
  end

  // Every unstalled cycle retires (or bubbles) exactly one EX/MEM entry.
  assign wb_load = ~o_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vld             <= 1'b0;
      o_rd_waddr        <= 5'd0;
      o_rd_wen          <= 1'b0;
      o_wb_data         <= 32'd0;
      o_pc              <= 32'd0;
      o_trap_misaligned <= 1'b0;
    end else if (wb_load) begin
      o_vld             <= i_vld;
      o_rd_waddr        <= i_rd_waddr;
      o_rd_wen          <= i_vld & i_rd_wen & ~misaligned & ~i_mem_write;
      o_wb_data         <= (state == WAIT && i_mem_reg) ? ld_data : i_res;
      o_pc              <= i_pc;
      o_trap_misaligned <= i_vld & misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-addressed reference memory predicts
// MEM/WB results and memory requests; a responder and a monitor check them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_vld, i_mem_read, i_mem_write, i_mem_reg, i_rd_wen;
  logic [31:0] i_res, i_wdata, i_pc;
  logic [2:0]  i_opsel;
  logic [4:0]  i_rd_waddr;
  logic        o_stall, o_vld, o_rd_wen, o_trap_misaligned;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_wb_data, o_pc;

  mem_stage_if dmem ();

  mem_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(i_vld), .i_res(i_res), .i_wdata(i_wdata),
    .i_opsel(i_opsel), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_reg(i_mem_reg), .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_pc(i_pc),
    .dmem(dmem), .o_stall(o_stall), .o_vld(o_vld), .o_rd_waddr(o_rd_waddr),
    .o_rd_wen(o_rd_wen), .o_wb_data(o_wb_data), .o_pc(o_pc),
    .o_trap_misaligned(o_trap_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wb;
    bit          chk_wb;
    logic [31:0] pc;
    logic        trap;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } req_exp_t;

  wb_exp_t     exp_q[$];
  req_exp_t    req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ready_delay = 0;
  int          rvalid_delay = 1;
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] dev_mem [int unsigned];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned widx);
    return widx * 32'h9E3779B1 ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned ba);
    logic [31:0] w;
    if (ref_mem.exists(ba)) return ref_mem[ba];
    w = init_word(ba / 4);
    return 8'(w >> (8 * (ba % 4)));
  endfunction

  function automatic logic [31:0] dev_rd(input int unsigned widx);
    return dev_mem.exists(widx) ? dev_mem[widx] : init_word(widx);
  endfunction

  function automatic int size_of(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 4;
  endfunction

  task automatic idle_inputs();
    i_vld       = 1'b0;
    i_mem_read  = 1'($urandom);
    i_mem_write = 1'($urandom);
    i_mem_reg   = 1'($urandom);
    i_opsel     = 3'($urandom);
    i_res       = $urandom;
    i_wdata     = $urandom;
    i_pc        = $urandom;
    i_rd_waddr  = 5'($urandom);
    i_rd_wen    = 1'($urandom);
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_vld", o_vld, 0);
    check("rst_rd_wen", o_rd_wen, 0);
    check("rst_rd_waddr", o_rd_waddr, 0);
    check("rst_wb_data", o_wb_data, 0);
    check("rst_pc", o_pc, 0);
    check("rst_trap", o_trap_misaligned, 0);
    check("rst_req", dmem.req, 0);
    check("rst_stall", o_stall, 0);
  endtask

  // Presents one valid EX/MEM entry, records the expected outcome, and holds it while stalled.
  task automatic issue(input bit mr, input bit mw, input bit mreg, input logic [2:0] op,
                       input logic [31:0] res, input logic [31:0] wd, input logic [31:0] pc,
                       input logic [4:0] rd, input logic wen, input int rdy_d, input int rv_d);
    wb_exp_t     e;
    req_exp_t    r;
    int          sz, a, stalls, exp_stalls;
    logic [31:0] ld;
    i_vld = 1'b1; i_mem_read = mr; i_mem_write = mw; i_mem_reg = mreg; i_opsel = op;
    i_res = res; i_wdata = wd; i_pc = pc; i_rd_waddr = rd; i_rd_wen = wen;
    ready_delay  = rdy_d;
    rvalid_delay = rv_d;
    sz = size_of(op);
    a  = int'(res[1:0]);
    e.rd = rd; e.wen = wen; e.wb = res; e.chk_wb = 1'b1; e.pc = pc; e.trap = 1'b0;
    exp_stalls = 0;
    if ((mr || mw) && (a % sz != 0)) begin
      e.trap = 1'b1; e.wen = 1'b0; e.chk_wb = 1'b0;
    end else if (mw) begin
      r.addr  = res & ~32'd3;
      r.wen   = 1'b1;
      r.mask  = 4'(((1 << sz) - 1) << a);
      r.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
      for (int i = 0; i < sz; i++) ref_mem[res + i] = 8'(wd >> (8 * i));
      e.wen = 1'b0; e.chk_wb = 1'b0;
      exp_stalls = 1 + rdy_d;
      req_q.push_back(r);
    end else if (mr) begin
      r.addr = res & ~32'd3; r.wen = 1'b0; r.mask = 4'b0000; r.wdata = 32'd0;
      ld = 32'd0;
      for (int i = 0; i < sz; i++) ld = ld | (32'(ref_rd(res + i)) << (8 * i));
      if (sz < 4 && op < 3'd4 && ld[8 * sz - 1]) ld = ld | (32'hFFFF_FFFF << (8 * sz));
      if (mreg) e.wb = ld;
      exp_stalls = rdy_d + rv_d + 1;
      req_q.push_back(r);
    end
    exp_q.push_back(e);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!o_stall) break;
      stalls++;
      if (stalls > 64) begin
        checks++; errors++;
        $display("FAIL stall_timeout: stalled %0d cycles, expected %0d", stalls, exp_stalls);
        break;
      end
    end
    check("stall_cycles", stalls, exp_stalls);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Memory responder: checks each request, inserts ready/rvalid delays, holds the data.
  initial begin
    req_exp_t    r;
    int          rd, rv;
    logic [31:0] w;
    dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && dmem.req === 1'b1) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got req=1 addr %h expected req=0", dmem.addr);
        end else begin
          r  = req_q.pop_front();
          rd = ready_delay;
          rv = rvalid_delay;
          for (int k = 0; k <= rd; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check("req_held", dmem.req, 1);
            check("req_addr", dmem.addr, r.addr);
            check("req_wen", dmem.wen, r.wen);
            check("req_mask", dmem.mask, r.mask);
            if (r.wen) check("req_wdata", dmem.wdata, r.wdata);
          end
          dmem.ready = 1'b1;
          @(posedge clk); #1;
          dmem.ready = 1'b0;
          if (r.wen) begin
            w = dev_rd(r.addr / 4);
            for (int b = 0; b < 4; b++) if (r.mask[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
            dev_mem[r.addr / 4] = w;
          end else begin
            repeat (rv - 1) begin @(posedge clk); #1; end
            dmem.rvalid = 1'b1;
            dmem.rdata  = dev_rd(r.addr / 4);
            @(posedge clk); #1;
            dmem.rvalid = 1'b0;
            dmem.rdata  = $urandom;
          end
        end
      end
    end
  end

  // Monitor: the MEM/WB register is rewritten on every edge that ends an unstalled cycle.
  initial begin
    wb_exp_t e;
    bit      upd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) upd = 1'b0;
      else begin
        if (upd) begin
          if (o_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_wb: got o_vld=1 pc %h expected o_vld=0", o_pc);
            end else begin
              e = exp_q.pop_front();
              check("wb_pc", o_pc, e.pc);
              check("wb_rd_wen", o_rd_wen, e.wen);
              check("wb_trap", o_trap_misaligned, e.trap);
              if (e.wen) check("wb_rd_waddr", o_rd_waddr, e.rd);
              if (e.chk_wb) check("wb_data", o_wb_data, e.wb);
            end
          end else begin
            check("bubble_rd_wen", o_rd_wen, 0);
          end
        end
        upd = !o_stall;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    req_exp_t r;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs();
    rst_n = 1'b1;
    bubble(2);

    issue(0, 0, 0, 3'd0, 32'h0000_1234, 32'h0, 32'h0000_0100, 5'd5, 1'b1, 0, 1);
    issue(0, 1, 0, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0000_0104, 5'd0, 1'b0, 0, 1);
    issue(0, 1, 0, 3'd2, 32'h0000_2000, 32'h0080_0000, 32'h0000_0108, 5'd0, 1'b0, 1, 1);
    issue(1, 0, 1, 3'd0, 32'h0000_2002, 32'h0, 32'h0000_010C, 5'd7, 1'b1, 2, 3);
    issue(1, 0, 1, 3'd4, 32'h0000_2002, 32'h0, 32'h0000_0110, 5'd8, 1'b1, 2, 3);
    @(negedge clk);
    @(posedge clk); #1;
    check("bubble_vld", o_vld, 0);
    check("bubble_wen", o_rd_wen, 0);
    issue(1, 0, 1, 3'd2, 32'h0000_3001, 32'h0, 32'h0000_0400, 5'd9, 1'b1, 0, 1);
    bubble(1);

    // Load abandoned by reset while waiting for its response.
    r.addr = 32'h0000_2000; r.wen = 1'b0; r.mask = 4'b0000; r.wdata = 32'd0;
    req_q.push_back(r);
    ready_delay = 0; rvalid_delay = 6;
    i_vld = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_reg = 1'b1; i_opsel = 3'd2;
    i_res = 32'h0000_2000; i_pc = 32'h0000_0500; i_rd_waddr = 5'd3; i_rd_wen = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("wait_stall", o_stall, 1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_reset_outputs();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    bubble(6);
    issue(0, 0, 0, 3'd1, 32'hCAFE_0001, 32'h0, 32'h0000_0600, 5'd11, 1'b1, 0, 1);

    for (int n = 0; n < 300; n++) begin
      int          kind;
      bit          mr, mw;
      logic [31:0] res;
      kind = $urandom_range(0, 2);
      mr   = (kind == 1);
      mw   = (kind == 2);
      res  = (kind == 0) ? $urandom : 32'h0000_1000 + $urandom_range(0, 63);
      issue(mr, mw, mr ? ($urandom_range(0, 3) != 0) : 1'($urandom), 3'($urandom_range(0, 7)),
            res, $urandom, $urandom, 5'($urandom), 1'($urandom),
            $urandom_range(0, 3), $urandom_range(1, 4));
      bubble($urandom_range(0, 2));
    end

    bubble(10);
    check("exp_q_drained", exp_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
